// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and inst_mem (slave).
// inst_mem is combinational, so rdata is valid in the same cycle as addr.
interface if_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads inst_mem and fills the IF/ID register.
// Handles stall, flush and EX redirect, and counts instructions loaded into IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    if_fetch_unit_if.master        imem,
    input  logic                   stall_f,
    input  logic                   stall_d,
    input  logic                   flush_d,
    input  logic                   pc_src_e,
    input  logic [31:0]            pc_target_e,
    output logic [31:0]            pc_f,
    output logic [31:0]            instr_d,
    output logic [31:0]            pc_d,
    output logic [31:0]            pc_plus4_d,
    output logic                   valid_d,
    output logic                   misalign_o,
    output logic [31:0]            fetch_count
);

    logic [31:0] pc_reg,          pc_next;
    logic [31:0] instr_reg,       instr_next;
    logic [31:0] pc_d_reg,        pc_d_next;
    logic [31:0] pc_plus4_d_reg,  pc_plus4_d_next;
    logic        valid_reg,       valid_next;
    logic        misalign_reg,    misalign_next;
    logic [31:0] fetch_count_reg, fetch_count_next;

    logic [31:0] pc_plus4;
    logic        load_d;

    assign pc_plus4 = pc_reg + 32'd4;

    // Redirect wins over stall_f; the low target bits are dropped so fetch stays word-aligned.
    always_comb begin
        pc_next = pc_plus4;
        if (pc_src_e) begin
            pc_next = {pc_target_e[31:2], 2'b00};
        end else if (stall_f) begin
            pc_next = pc_reg;
        end
    end

    assign misalign_next = pc_src_e & (pc_target_e[1:0] != 2'b00);

    // flush_d wins over stall_d; a redirect alone does not squash the wrong-path word.
    assign load_d = ~flush_d & ~stall_d;

    always_comb begin
        instr_next      = instr_reg;
        pc_d_next       = pc_d_reg;
        pc_plus4_d_next = pc_plus4_d_reg;
        valid_next      = valid_reg;
        if (flush_d) begin
            instr_next      = NOP_INSTR;
            pc_d_next       = 32'd0;
            pc_plus4_d_next = 32'd0;
            valid_next      = 1'b0;
        end else if (!stall_d) begin
            instr_next      = imem.imem_rdata;
            pc_d_next       = pc_reg;
            pc_plus4_d_next = pc_plus4;
            valid_next      = 1'b1;
        end
    end

    assign fetch_count_next = load_d ? fetch_count_reg + 32'd1 : fetch_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            instr_reg       <= NOP_INSTR;
            pc_d_reg        <= 32'd0;
            pc_plus4_d_reg  <= 32'd0;
            valid_reg       <= 1'b0;
            misalign_reg    <= 1'b0;
            fetch_count_reg <= 32'd0;
        end else begin
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            pc_d_reg        <= pc_d_next;
            pc_plus4_d_reg  <= pc_plus4_d_next;
            valid_reg       <= valid_next;
            misalign_reg    <= misalign_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    assign imem.imem_addr = pc_reg;
    assign pc_f           = pc_reg;
    assign instr_d        = instr_reg;
    assign pc_d           = pc_d_reg;
    assign pc_plus4_d     = pc_plus4_d_reg;
    assign valid_d        = valid_reg;
    assign misalign_o     = misalign_reg;
    assign fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table for the corner cases, then
// randomized control inputs checked against a cycle-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d, misalign_o;

    if_fetch_unit_if imem_bus ();

    // Memory model: every word encodes its own address.
    assign imem_bus.imem_rdata = 32'hA000_0000 | imem_bus.imem_addr;

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus.master),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .misalign_o  (misalign_o),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_cnt;
    logic        m_valid, m_mis;

    typedef struct {
        logic        rst, sf, sd, fl, ps;
        logic [31:0] tgt;
        logic [31:0] pc, instr, pcd, p4;
        logic        v, mis;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the documented rules, take the edge.
    task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                        input logic ps, input logic [31:0] tgt);
        logic [31:0] word;
        reset = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps; pc_target_e = tgt;
        word = 32'hA000_0000 | m_pc;
        if (r) begin
            m_pc = 32'd0; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else begin
            m_mis = ps && (tgt % 4 != 0);
            if (fl) begin
                m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0;
            end else if (!sd) begin
                m_instr = word; m_pcd = m_pc; m_p4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            end
            if (ps)       m_pc = tgt - (tgt % 4);
            else if (!sf) m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc_f"},        pc_f,                m_pc);
        check({tag, " imem_addr"},   imem_bus.imem_addr,  m_pc);
        check({tag, " instr_d"},     instr_d,             m_instr);
        check({tag, " pc_d"},        pc_d,                m_pcd);
        check({tag, " pc_plus4_d"},  pc_plus4_d,          m_p4);
        check({tag, " valid_d"},     {31'd0, valid_d},    {31'd0, m_valid});
        check({tag, " misalign_o"},  {31'd0, misalign_o}, {31'd0, m_mis});
        check({tag, " fetch_count"}, fetch_count,         m_cnt);
    endtask

    initial begin
        //            rst sf sd fl ps tgt            pc            instr         pc_d          pc+4          v  mis cnt
        vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        32'h4,        32'hA0000000, 32'h0,        32'h4,        1, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,        32'h8,        32'hA0000004, 32'h4,        32'h8,        1, 0, 2};
        vecs[3]  = '{0, 1, 1, 0, 0, 32'h0,        32'h8,        32'hA0000004, 32'h4,        32'h8,        1, 0, 2};
        vecs[4]  = '{0, 1, 1, 0, 0, 32'h0,        32'h8,        32'hA0000004, 32'h4,        32'h8,        1, 0, 2};
        vecs[5]  = '{0, 0, 0, 0, 0, 32'h0,        32'hC,        32'hA0000008, 32'h8,        32'hC,        1, 0, 3};
        vecs[6]  = '{0, 1, 0, 1, 1, 32'h40,       32'h40,       NOP,          32'h0,        32'h0,        0, 0, 3};
        vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,        32'h44,       32'hA0000040, 32'h40,       32'h44,       1, 0, 4};
        vecs[8]  = '{0, 0, 0, 0, 1, 32'h102,      32'h100,      32'hA0000044, 32'h44,       32'h48,       1, 1, 5};
        vecs[9]  = '{0, 0, 0, 0, 0, 32'h0,        32'h104,      32'hA0000100, 32'h100,      32'h104,      1, 0, 6};
        vecs[10] = '{0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,          32'h0,        32'h0,        0, 0, 6};
        vecs[11] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        1, 0, 7};
        vecs[12] = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        1, 0, 7};
        vecs[13] = '{1, 1, 1, 1, 1, 32'h203,      32'h0,        NOP,          32'h0,        32'h0,        0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 32'h0,        32'h4,        32'hA0000000, 32'h0,        32'h4,        1, 0, 1};
        vecs[15] = '{0, 1, 0, 0, 0, 32'h0,        32'h4,        32'hA0000004, 32'h4,        32'h8,        1, 0, 2};
        vecs[16] = '{0, 1, 0, 0, 0, 32'h0,        32'h4,        32'hA0000004, 32'h4,        32'h8,        1, 0, 3};

        reset = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
        m_pc = 0; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].ps, vecs[i].tgt);
            check("vec pc_f",        pc_f,                vecs[i].pc);
            check("vec imem_addr",   imem_bus.imem_addr,  vecs[i].pc);
            check("vec instr_d",     instr_d,             vecs[i].instr);
            check("vec pc_d",        pc_d,                vecs[i].pcd);
            check("vec pc_plus4_d",  pc_plus4_d,          vecs[i].p4);
            check("vec valid_d",     {31'd0, valid_d},    {31'd0, vecs[i].v});
            check("vec misalign_o",  {31'd0, misalign_o}, {31'd0, vecs[i].mis});
            check("vec fetch_count", fetch_count,         vecs[i].cnt);
            $display("[TB] vec %0d: pc_f=%08h instr_d=%08h pc_d=%08h valid=%0b mis=%0b cnt=%0d",
                     i, pc_f, instr_d, pc_d, valid_d, misalign_o, fetch_count);
        end

        // Misaligned redirect held for two cycles pulses once per redirect, then drops.
        step(0, 0, 0, 1, 1, 32'h301);
        check("seq mis first", {31'd0, misalign_o}, 32'd1);
        step(0, 0, 0, 1, 1, 32'h402);
        check("seq mis second", {31'd0, misalign_o}, 32'd1);
        check("seq pc aligned", pc_f, 32'h400);
        step(0, 0, 0, 0, 0, 32'h0);
        check("seq mis cleared", {31'd0, misalign_o}, 32'd0);
        check_model("seq");
        $display("[TB] seq misalign: pc_f=%08h mis=%0b", pc_f, misalign_o);

        // Randomized control stream against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic        r, sf, sd, fl, ps;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 63) == 0);
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            ps  = ($urandom_range(0, 4) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(r, sf, sd, fl, ps, tgt);
            check_model("rnd");
        end
        $display("[TB] random phase done: pc_f=%08h fetch_count=%0d", pc_f, fetch_count);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
